// File: rtl/common_types.sv
// Shared type definitions for the memory address path.
package common_types;

    typedef logic [15:0] addr_t;

    // Memory address mux select: program counter or address register.
    typedef enum logic {
        PC_ADDR  = 1'b0,
        ADDR_REG = 1'b1
    } mm_t;

endpackage

// File: rtl/addr_gen.sv
// addr_gen: multi-cycle 6502 effective-address generator.
// Fetches operand bytes through the PC side of the address mux and pointer
// bytes through the address register side, applies X/Y indexing with 8-bit
// adders and an explicit carry/fix-up cycle, and reports the result on ea.
// All outputs are registered: each state branch sets the outputs the next
// state presents.
module addr_gen
    import common_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  mode,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [7:0]  data_in,
    output mm_t         mm,
    output addr_t       addr,
    output logic        pc_inc,
    output logic        busy,
    output logic        done,
    output addr_t       ea,
    output logic        page_cross
);

    localparam logic [3:0] M_ZP   = 4'd0;
    localparam logic [3:0] M_ZPX  = 4'd1;
    localparam logic [3:0] M_ZPY  = 4'd2;
    localparam logic [3:0] M_ABS  = 4'd3;
    localparam logic [3:0] M_ABSX = 4'd4;
    localparam logic [3:0] M_ABSY = 4'd5;
    localparam logic [3:0] M_IND  = 4'd6;
    localparam logic [3:0] M_INDX = 4'd7;
    localparam logic [3:0] M_INDY = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE, S_OPL, S_OPH, S_OPW, S_ZPW, S_PL, S_PH, S_PW, S_FIX, S_DONE
    } state_t;

    state_t     state;
    logic [3:0] mode_r;
    logic [7:0] x_r;
    logic [7:0] y_r;
    logic [7:0] op_lo;
    logic [7:0] ea_lo;
    logic [7:0] ea_hi;

    // 8-bit add returning {carry, sum}.
    function automatic logic [8:0] add8(input logic [7:0] a, input logic [7:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // 8-bit add with the carry discarded (zero-page and pointer wrap).
    function automatic logic [7:0] wrap8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    logic [7:0] idx;
    logic [8:0] abs_sum;
    logic [7:0] zp_sum;
    logic [8:0] indy_sum;

    // X indexes ZPX/ABSX/INDX; every other indexed mode uses Y.
    assign idx      = (mode_r == M_ZPX || mode_r == M_ABSX || mode_r == M_INDX) ? x_r : y_r;
    assign abs_sum  = add8(op_lo, idx);
    assign zp_sum   = wrap8(data_in, idx);
    assign indy_sum = add8(ea_lo, y_r);

    // Address-generation FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            mode_r     <= '0;
            x_r        <= '0;
            y_r        <= '0;
            op_lo      <= '0;
            ea_lo      <= '0;
            ea_hi      <= '0;
            mm         <= PC_ADDR;
            addr       <= '0;
            pc_inc     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ea         <= '0;
            page_cross <= 1'b0;
        end else begin
            pc_inc <= 1'b0;
            done   <= 1'b0;
            mm     <= ADDR_REG;
            busy   <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_r     <= mode;
                        x_r        <= x;
                        y_r        <= y;
                        page_cross <= 1'b0;
                        if (mode <= M_INDY) begin
                            state  <= S_OPL;
                            mm     <= PC_ADDR;
                            pc_inc <= 1'b1;
                        end else begin
                            // Unknown mode: finish at once with a null address.
                            state <= S_DONE;
                            ea    <= '0;
                            addr  <= '0;
                            done  <= 1'b1;
                        end
                    end else begin
                        mm   <= PC_ADDR;
                        busy <= 1'b0;
                    end
                end
                S_OPL: begin
                    if (mode_r == M_ABS || mode_r == M_ABSX ||
                        mode_r == M_ABSY || mode_r == M_IND) begin
                        state  <= S_OPH;
                        mm     <= PC_ADDR;
                        pc_inc <= 1'b1;
                    end else begin
                        state <= S_ZPW;
                    end
                end
                S_OPH: begin
                    op_lo <= data_in;
                    state <= S_OPW;
                end
                S_OPW: begin
                    case (mode_r)
                        M_ABSX, M_ABSY: begin
                            ea_hi <= data_in;
                            ea_lo <= abs_sum[7:0];
                            if (abs_sum[8]) begin
                                state <= S_FIX;
                            end else begin
                                ea    <= {data_in, abs_sum[7:0]};
                                addr  <= {data_in, abs_sum[7:0]};
                                done  <= 1'b1;
                                state <= S_DONE;
                            end
                        end
                        M_IND: begin
                            addr  <= {data_in, op_lo};
                            state <= S_PL;
                        end
                        default: begin
                            ea    <= {data_in, op_lo};
                            addr  <= {data_in, op_lo};
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    endcase
                end
                S_ZPW: begin
                    op_lo <= data_in;
                    case (mode_r)
                        M_ZPX, M_ZPY: begin
                            ea    <= {8'h00, zp_sum};
                            addr  <= {8'h00, zp_sum};
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                        M_INDX: begin
                            addr  <= {8'h00, zp_sum};
                            state <= S_PL;
                        end
                        M_INDY: begin
                            addr  <= {8'h00, data_in};
                            state <= S_PL;
                        end
                        default: begin
                            ea    <= {8'h00, data_in};
                            addr  <= {8'h00, data_in};
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    endcase
                end
                S_PL: begin
                    // Pointer high byte is never incremented: zero-page wrap
                    // and the JMP (ind) page bug both fall out of this.
                    addr  <= {addr[15:8], wrap8(addr[7:0], 8'h01)};
                    state <= S_PH;
                end
                S_PH: begin
                    ea_lo <= data_in;
                    state <= S_PW;
                end
                S_PW: begin
                    if (mode_r == M_INDY) begin
                        ea_hi <= data_in;
                        ea_lo <= indy_sum[7:0];
                        if (indy_sum[8]) begin
                            state <= S_FIX;
                        end else begin
                            ea    <= {data_in, indy_sum[7:0]};
                            addr  <= {data_in, indy_sum[7:0]};
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else begin
                        ea    <= {data_in, ea_lo};
                        addr  <= {data_in, ea_lo};
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_FIX: begin
                    ea         <= {wrap8(ea_hi, 8'h01), ea_lo};
                    addr       <= {wrap8(ea_hi, 8'h01), ea_lo};
                    page_cross <= 1'b1;
                    done       <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    mm    <= PC_ADDR;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    mm    <= PC_ADDR;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
